switch_debouncer: RTL and testbench

- Upstream conditioning stage for the switch-to-LED/7-segment display block.
- Takes the raw, asynchronous slide-switch bus and synchronises each bit to the system clock.
- Filters out contact bounce per bit and presents a clean, stable switch state.
- Also produces one-cycle rise/fall event pulses, so downstream logic can react to toggles.

---
 rtl/switch_debouncer.sv | 97 +++++++++
 tb/tb_switch_debouncer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Synchronises a raw slide-switch bus to the system clock, filters contact
//   bounce per bit and presents a clean switch state plus one-cycle edge events.
//
// Parameters:
//   WIDTH         number of switch bits (bus order [0:WIDTH-1], bit 0 = leftmost)
//   STABLE_CYCLES consecutive differing cycles needed to accept a new state
//                 (1 .. 2^CNT_W-1)
//   CNT_W         width of each per-bit stability counter
//
// Ports:
//   clock      system clock, rising-edge active
//   reset      synchronous active-high reset
//   SW         raw switch inputs, asynchronous to clock (1 = switch up)
//   state      debounced switch state, registered
//   rise       one-cycle pulse when a state bit goes 0->1
//   fall       one-cycle pulse when a state bit goes 1->0
//   any_change registered OR of all rise/fall bits, aligned with those pulses
module switch_debouncer #(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned CNT_W         = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:WIDTH-1] SW,
    output logic [0:WIDTH-1] state,
    output logic [0:WIDTH-1] rise,
    output logic [0:WIDTH-1] fall,
    output logic             any_change
);

    // Terminal count: the cycle on which the new value is accepted.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [0:WIDTH-1] s1_q;
    logic [0:WIDTH-1] s2_q;
    logic [0:WIDTH-1] state_q, state_d;
    logic [0:WIDTH-1] rise_q, rise_d;
    logic [0:WIDTH-1] fall_q, fall_d;
    logic             any_change_q, any_change_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Per-bit filter. The counter only runs while the synchronised input
    // disagrees with the accepted state; any agreement clears it, so stability
    // is measured over consecutive cycles only.
    always_comb begin
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    state_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Computed from the next-state pulses so it lands in the same cycle.
        any_change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            state_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= SW;
            s2_q         <= s1_q;
            state_q      <= state_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign state      = state_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: a STABLE_CYCLES=4 instance for the main
// sequence and a STABLE_CYCLES=1 instance for the pass-through case.
module tb_switch_debouncer;

    logic       clock;
    logic       reset;
    logic [0:5] sw4, sw1;
    logic [0:5] state4, rise4, fall4;
    logic [0:5] state1, rise1, fall1;
    logic       any4, any1;

    int total = 0;
    int bad   = 0;

    switch_debouncer #(
        .WIDTH(6),
        .STABLE_CYCLES(4),
        .CNT_W(19)
    ) dut4 (
        .clock(clock),
        .reset(reset),
        .SW(sw4),
        .state(state4),
        .rise(rise4),
        .fall(fall4),
        .any_change(any4)
    );

    switch_debouncer #(
        .WIDTH(6),
        .STABLE_CYCLES(1),
        .CNT_W(19)
    ) dut1 (
        .clock(clock),
        .reset(reset),
        .SW(sw1),
        .state(state1),
        .rise(rise1),
        .fall(fall1),
        .any_change(any1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then step off it before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks every output of the STABLE_CYCLES=4 instance.
    task automatic chk4(input string tag, input logic [0:5] st, input logic [0:5] ri,
                        input logic [0:5] fa, input logic an);
        chk({tag, ".state"}, state4, st);
        chk({tag, ".rise"}, rise4, ri);
        chk({tag, ".fall"}, fall4, fa);
        chk({tag, ".any"}, {5'b0, any4}, {5'b0, an});
    endtask

    logic       hist [24];
    logic       ev_now, ev_prev;

    initial begin
        reset = 1'b1;
        sw4   = '0;
        sw1   = '0;
        tick();
        tick();
        chk4("reset", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        chk("reset1.state", state1, 6'b000000);
        reset = 1'b0;

        // Quiet input: nothing moves.
        for (int k = 0; k < 20; k++) begin
            tick();
            chk4("quiet", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        end

        // Single bit rise, accepted on the 6th edge after the change.
        sw4 = 6'b100000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk4("rise0", (k >= 6) ? 6'b100000 : 6'b000000,
                 (k == 6) ? 6'b100000 : 6'b000000, 6'b000000, k == 6);
        end

        // Bounce: 3-cycle pulses never reach the terminal count.
        for (int r = 0; r < 5; r++) begin
            sw4 = 6'b101000;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk4("bounce_hi", 6'b100000, 6'b000000, 6'b000000, 1'b0);
            end
            sw4 = 6'b100000;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk4("bounce_lo", 6'b100000, 6'b000000, 6'b000000, 1'b0);
            end
        end
        sw4 = 6'b101000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk4("hold2", (k >= 6) ? 6'b101000 : 6'b100000,
                 (k == 6) ? 6'b001000 : 6'b000000, 6'b000000, k == 6);
        end

        // Settle all-up, then drop bits 0, 2, 4 together.
        sw4 = 6'b111111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk4("all_up", (k >= 6) ? 6'b111111 : 6'b101000,
                 (k == 6) ? 6'b010111 : 6'b000000, 6'b000000, k == 6);
        end
        sw4 = 6'b010101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk4("multi_fall", (k >= 6) ? 6'b010101 : 6'b111111, 6'b000000,
                 (k == 6) ? 6'b101010 : 6'b000000, k == 6);
        end

        // Reset in the middle of a count on bit 5.
        reset = 1'b1;
        sw4   = 6'b000000;
        tick();
        chk4("reset2", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        reset = 1'b0;
        sw4   = 6'b000001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk4("precount5", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk4("midreset", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk4("after_reset5", (k >= 6) ? 6'b000001 : 6'b000000,
                 (k == 6) ? 6'b000001 : 6'b000000, 6'b000000, k == 6);
        end

        // STABLE_CYCLES=1: bit 1 toggles every 3 cycles, state lags by 3 edges
        // (the value driven before tick k appears after tick k+2).
        for (int k = 0; k < 24; k++) begin
            hist[k] = ((k / 3) % 2) == 0;
            sw1     = {1'b0, hist[k], 4'b0000};
            tick();
            ev_now  = (k >= 2) ? hist[k-2] : 1'b0;
            ev_prev = (k >= 3) ? hist[k-3] : 1'b0;
            chk("sc1.state", state1, {1'b0, ev_now, 4'b0000});
            chk("sc1.rise", rise1, {1'b0, ev_now & ~ev_prev, 4'b0000});
            chk("sc1.fall", fall1, {1'b0, ~ev_now & ev_prev, 4'b0000});
            chk("sc1.any", {5'b0, any1}, {5'b0, ev_now ^ ev_prev});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
